branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_if.sv | 46 ++++
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bus of the branch resolve unit.
// Stats outputs exist only when BRANCH_RESOLVE_STATS_EN is defined.
interface branch_resolve_unit_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    localparam int TAG_W = $clog2(DEPTH)
);
    logic             alloc_valid;
    logic [PC_W-1:0]  alloc_pc;
    logic [PC_W-1:0]  alloc_pred_target;
    logic             alloc_pred_taken;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    logic [PC_W-1:0]  res_target;

    logic             flush;
    logic [TAG_W-1:0] flush_tag;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0]      stat_resolved;
    logic [31:0]      stat_mispred;
`endif

    modport master (
`ifdef BRANCH_RESOLVE_STATS_EN
        input  stat_resolved, stat_mispred,
`endif
        output alloc_valid, alloc_pc, alloc_pred_target, alloc_pred_taken,
        output res_valid, res_tag, res_taken, res_target,
        input  alloc_ready, alloc_tag, flush, flush_tag, redirect_valid, redirect_pc
    );

    modport slave (
`ifdef BRANCH_RESOLVE_STATS_EN
        output stat_resolved, stat_mispred,
`endif
        input  alloc_valid, alloc_pc, alloc_pred_target, alloc_pred_taken,
        input  res_valid, res_tag, res_taken, res_target,
        output alloc_ready, alloc_tag, flush, flush_tag, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order branch tracking buffer: allocates tags, detects mispredicts, flushes/redirects.
// Optional counters enabled by BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2,
    localparam int TAG_W       = $clog2(DEPTH)
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic                       flush_c;

    logic [TAG_W:0]             head, tail;
    logic [DEPTH-1:0]           ent_valid, ent_resolved, ent_pred_taken;
    logic [DEPTH-1:0][PC_W-1:0] ent_pc, ent_pred_target;

    logic [TAG_W-1:0]           head_idx, tail_idx, rtag, res_off;
    logic [TAG_W:0]             res_ptr;
    logic                       full, alloc_ok, alloc_fire;
    logic                       res_hit, mispred, res_ok, retire;
    logic [DEPTH-1:0]           younger;
    logic [PC_W-1:0]            redir_pc_c;

    assign head_idx   = head[TAG_W-1:0];
    assign tail_idx   = tail[TAG_W-1:0];
    assign rtag       = bus.res_tag;
    assign full       = (tail - head) == (TAG_W+1)'(DEPTH);
    assign alloc_ok   = !full && (state == IDLE);
    assign alloc_fire = bus.alloc_valid && alloc_ok;

    // Only live, not-yet-resolved entries react to a resolve.
    assign res_hit = bus.res_valid && ent_valid[rtag] && !ent_resolved[rtag];
    assign mispred = res_hit &&
                     ((ent_pred_taken[rtag] != bus.res_taken) ||
                      (bus.res_taken && (ent_pred_target[rtag] != bus.res_target)));
    assign res_ok  = res_hit && !mispred;
    assign retire  = ent_valid[head_idx] && ent_resolved[head_idx];

    // Age of the resolved entry relative to head; rebuild its full pointer so the wrap bit stays right.
    assign res_off    = rtag - head_idx;
    assign res_ptr    = head + {1'b0, res_off};
    assign redir_pc_c = bus.res_taken ? bus.res_target : ent_pc[rtag] + PC_W'(4);

    always_comb begin
        younger = '0;
        for (int i = 0; i < DEPTH; i++)
            younger[i] = (TAG_W'(i) - head_idx) > res_off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush_c   = 1'b0;
        case (state)
            IDLE: begin
                if (mispred) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (mispred)
                    cnt_nxt = CNT_LOAD;
                else if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head            <= '0;
            tail            <= '0;
            ent_valid       <= '0;
            ent_resolved    <= '0;
            ent_pred_taken  <= '0;
            ent_pc          <= '0;
            ent_pred_target <= '0;
        end else begin
            // A mispredict in the same cycle means this alloc is on the wrong path.
            if (alloc_fire && !mispred) begin
                ent_valid[tail_idx]       <= 1'b1;
                ent_resolved[tail_idx]    <= 1'b0;
                ent_pc[tail_idx]          <= bus.alloc_pc;
                ent_pred_taken[tail_idx]  <= bus.alloc_pred_taken;
                ent_pred_target[tail_idx] <= bus.alloc_pred_target;
                tail                      <= tail + 1'b1;
            end
            if (retire) begin
                ent_valid[head_idx]    <= 1'b0;
                ent_resolved[head_idx] <= 1'b0;
                head                   <= head + 1'b1;
            end
            if (res_ok)
                ent_resolved[rtag] <= 1'b1;
            if (mispred) begin
                ent_resolved[rtag] <= 1'b1;
                tail               <= res_ptr + 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (younger[i]) begin
                        ent_valid[i]    <= 1'b0;
                        ent_resolved[i] <= 1'b0;
                    end
                end
            end
        end
    end

    logic             redirect_valid_q;
    logic [PC_W-1:0]  redirect_pc_q;
    logic [TAG_W-1:0] flush_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_tag_q      <= '0;
        end else begin
            redirect_valid_q <= mispred;
            if (mispred) begin
                redirect_pc_q <= redir_pc_c;
                flush_tag_q   <= rtag;
            end
        end
    end

    assign bus.alloc_ready    = alloc_ok;
    assign bus.alloc_tag      = tail_idx;
    assign bus.flush          = flush_c;
    assign bus.flush_tag      = flush_tag_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_res_q, stat_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (res_hit && (stat_res_q != '1))
                stat_res_q <= stat_res_q + 1'b1;
            if (mispred && (stat_mis_q != '1))
                stat_mis_q <= stat_mis_q + 1'b1;
        end
    end

    assign bus.stat_resolved = stat_res_q;
    assign bus.stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected redirects queued at resolve time,
// popped when redirect_valid is seen; state checks inline.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    branch_resolve_unit_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc[DEPTH];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Every redirect must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.redirect_valid) begin
            if (sb.size() == 0) begin
                chk("unexp_redirect", 64'(bus.redirect_pc), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("redir_pc", 64'(bus.redirect_pc), 64'(e.pc));
                chk("redir_tag", 64'(bus.flush_tag), 64'(e.tag));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.alloc_valid       = 1'b0;
        bus.alloc_pc          = '0;
        bus.alloc_pred_target = '0;
        bus.alloc_pred_taken  = 1'b0;
        bus.res_valid         = 1'b0;
        bus.res_tag           = '0;
        bus.res_taken         = 1'b0;
        bus.res_target        = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                            input logic [1:0] exp_tag);
        bus.alloc_valid       = 1'b1;
        bus.alloc_pc          = pc;
        bus.alloc_pred_taken  = pt;
        bus.alloc_pred_target = tgt;
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(1));
        chk("alloc_tag", 64'(bus.alloc_tag), 64'(exp_tag));
        m_pc[exp_tag] = pc;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic do_res(input logic [1:0] tag, input logic taken, input logic [31:0] tgt,
                          input logic mis);
        bus.res_valid  = 1'b1;
        bus.res_tag    = tag;
        bus.res_taken  = taken;
        bus.res_target = tgt;
        if (mis) sb.push_back('{tag, taken ? tgt : m_pc[tag] + 32'd4});
        tick();
        bus.res_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        tick();
        // Reset values while held in reset
        chk("rst_flush", 64'(bus.flush), 64'(0));
        chk("rst_rv", 64'(bus.redirect_valid), 64'(0));
        chk("rst_rpc", 64'(bus.redirect_pc), 64'(0));
        chk("rst_ftag", 64'(bus.flush_tag), 64'(0));
        chk("rst_ready", 64'(bus.alloc_ready), 64'(1));
        chk("rst_tag", 64'(bus.alloc_tag), 64'(0));

        // Fill to capacity, then a correct resolve of tag0 retires it
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_alloc(32'h100 + 32'(i) * 32'h10, 1'b1, 32'h200, 2'(i));
        chk("full_ready", 64'(bus.alloc_ready), 64'(0));
        do_res(2'd0, 1'b1, 32'h200, 1'b0);
        chk("ok_noflush", 64'(bus.flush), 64'(0));
        tick();
        chk("retire_ready", 64'(bus.alloc_ready), 64'(1));
        chk("retire_tag", 64'(bus.alloc_tag), 64'(0));

        // Not-taken mispredict of a predicted-taken branch
        do_reset();
        do_alloc(32'h100, 1'b1, 32'h200, 2'd0);
        do_res(2'd0, 1'b0, 32'h0, 1'b1);
        chk("mp_flush1", 64'(bus.flush), 64'(1));
        chk("mp_rv1", 64'(bus.redirect_valid), 64'(1));
        chk("mp_rpc", 64'(bus.redirect_pc), 64'(32'h104));
        tick();
        chk("mp_flush2", 64'(bus.flush), 64'(1));
        chk("mp_rv2", 64'(bus.redirect_valid), 64'(0));
        chk("mp_ready_fl", 64'(bus.alloc_ready), 64'(0));
        tick();
        chk("mp_flush3", 64'(bus.flush), 64'(0));
        chk("mp_ready", 64'(bus.alloc_ready), 64'(1));
        chk("mp_tag", 64'(bus.alloc_tag), 64'(1));

        // Mispredict tag1 squashes 2,3; stale resolve of tag3 ignored
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_alloc(32'h10 + 32'(i) * 32'h10, 1'b0, 32'h0, 2'(i));
        do_res(2'd1, 1'b1, 32'h500, 1'b1);
        chk("sq_ftag", 64'(bus.flush_tag), 64'(1));
        tick();
        tick();
        chk("sq_flush_done", 64'(bus.flush), 64'(0));
        chk("sq_tag", 64'(bus.alloc_tag), 64'(2));
        do_res(2'd3, 1'b1, 32'h999, 1'b0);
        chk("sq_ign_flush", 64'(bus.flush), 64'(0));
        chk("sq_ign_rv", 64'(bus.redirect_valid), 64'(0));
        do_alloc(32'h50, 1'b0, 32'h0, 2'd2);

        // Older mispredict during flush restarts it
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_alloc(32'h10 + 32'(i) * 32'h10, 1'b0, 32'h0, 2'(i));
        do_res(2'd2, 1'b1, 32'h300, 1'b1);
        chk("nest_ftag_a", 64'(bus.flush_tag), 64'(2));
        do_res(2'd0, 1'b1, 32'h400, 1'b1);
        chk("nest_flush1", 64'(bus.flush), 64'(1));
        chk("nest_ftag_b", 64'(bus.flush_tag), 64'(0));
        chk("nest_rpc", 64'(bus.redirect_pc), 64'(32'h400));
        chk("nest_rv", 64'(bus.redirect_valid), 64'(1));
        tick();
        chk("nest_flush2", 64'(bus.flush), 64'(1));
        chk("nest_rv2", 64'(bus.redirect_valid), 64'(0));
        tick();
        chk("nest_flush3", 64'(bus.flush), 64'(0));
        chk("nest_tag", 64'(bus.alloc_tag), 64'(1));

        // Alloc in the mispredict cycle is dropped
        do_reset();
        do_alloc(32'h80, 1'b0, 32'h0, 2'd0);
        bus.alloc_valid       = 1'b1;
        bus.alloc_pc          = 32'h90;
        bus.alloc_pred_taken  = 1'b0;
        bus.alloc_pred_target = 32'h0;
        chk("drop_ready", 64'(bus.alloc_ready), 64'(1));
        chk("drop_tag_pre", 64'(bus.alloc_tag), 64'(1));
        do_res(2'd0, 1'b1, 32'h700, 1'b1);
        bus.alloc_valid = 1'b0;
        chk("drop_flush", 64'(bus.flush), 64'(1));
        tick();
        tick();
        chk("drop_tag", 64'(bus.alloc_tag), 64'(1));
        do_res(2'd1, 1'b1, 32'h123, 1'b0);
        chk("drop_ign_flush", 64'(bus.flush), 64'(0));
        do_alloc(32'hA0, 1'b0, 32'h0, 2'd1);

        // Reset pulse in the middle of a flush
        do_res(2'd1, 1'b1, 32'h800, 1'b1);
        chk("rf_flush", 64'(bus.flush), 64'(1));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rf_flush0", 64'(bus.flush), 64'(0));
        chk("rf_rv0", 64'(bus.redirect_valid), 64'(0));
        chk("rf_rpc0", 64'(bus.redirect_pc), 64'(0));
        chk("rf_ftag0", 64'(bus.flush_tag), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rf_ready", 64'(bus.alloc_ready), 64'(1));
        chk("rf_tag", 64'(bus.alloc_tag), 64'(0));
        tick();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
